bid_round_ctrl: RTL and testbench

Round controller and arbiter for the three-bidder (X, Y, Z) auction datapath. Sequences one bidding round: opens it on the controller start level, runs the round timer, and arbitrates simultaneous bids and retracts. Tracks the leader and maximum bid, checks balance sufficiency, and issues per-bidder ack/err plus charge strobes. On round close it publishes the winner and maxBid to the balance/settlement logic.

---
 rtl/bid_round_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_bid_round_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bid_round_ctrl.sv
// rtl/bid_round_ctrl.sv - round controller and bid arbiter for the X/Y/Z auction datapath
//
// Purpose: opens a bidding round on a fresh rising C_start level, counts the
// round down, arbitrates same-cycle bids/retracts from three bidders, tracks
// the leader and maximum bid, and publishes winner/maxBid when the round closes.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   C_start                         round enable level
//   timer_load, timer_value         reload register write (IDLE only)
//   xyz_mask                        bidder enable {Z,Y,X}, latched at round entry
//   bid_charge                      per-attempt charge
//   {X,Y,Z}_bid/_bidAmt/_retract    bid and retract requests
//   {X,Y,Z}_balance                 balances from the datapath
//   {X,Y,Z}_ack/_err                registered response pulse and code
//   charge_en                       {Z,Y,X} deduct-bid_charge strobe
//   {X,Y,Z}_win, maxBid, ready      round result, held until next round entry
//   roundOver                       one-cycle pulse in the DONE cycle

module bid_round_ctrl #(
  parameter int                 BID_W         = 16,
  parameter int                 BAL_W         = 32,
  parameter int                 TIMER_W       = 16,
  parameter logic [TIMER_W-1:0] DEFAULT_TIMER = 16'h000F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               C_start,
  input  logic               timer_load,
  input  logic [TIMER_W-1:0] timer_value,
  input  logic [2:0]         xyz_mask,
  input  logic [BAL_W-1:0]   bid_charge,
  input  logic               X_bid,
  input  logic               Y_bid,
  input  logic               Z_bid,
  input  logic [BID_W-1:0]   X_bidAmt,
  input  logic [BID_W-1:0]   Y_bidAmt,
  input  logic [BID_W-1:0]   Z_bidAmt,
  input  logic               X_retract,
  input  logic               Y_retract,
  input  logic               Z_retract,
  input  logic [BAL_W-1:0]   X_balance,
  input  logic [BAL_W-1:0]   Y_balance,
  input  logic [BAL_W-1:0]   Z_balance,
  output logic               X_ack,
  output logic               Y_ack,
  output logic               Z_ack,
  output logic [1:0]         X_err,
  output logic [1:0]         Y_err,
  output logic [1:0]         Z_err,
  output logic [2:0]         charge_en,
  output logic               X_win,
  output logic               Y_win,
  output logic               Z_win,
  output logic [BID_W-1:0]   maxBid,
  output logic               roundOver,
  output logic               ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TIMER_W-1:0] r_reload;
  logic [TIMER_W-1:0] r_count;
  logic [2:0]         r_mask;
  logic [2:0]         r_leader;    // one-hot, zero when nobody leads
  logic [BID_W-1:0]   r_max_bid;
  logic [2:0]         r_win;
  logic               r_ready;
  logic               r_armed;
  logic [2:0]         r_ack;
  logic [1:0]         r_err [3];
  logic [2:0]         r_charge;

  // Per-bidder views so the evaluation logic can loop over bidders.
  logic [2:0]         w_bid;
  logic [2:0]         w_ret;
  logic [BID_W-1:0]   w_amt [3];
  logic [BAL_W-1:0]   w_bal [3];

  assign w_bid    = {Z_bid, Y_bid, X_bid};
  assign w_ret    = {Z_retract, Y_retract, X_retract};
  assign w_amt[0] = X_bidAmt;
  assign w_amt[1] = Y_bidAmt;
  assign w_amt[2] = Z_bidAmt;
  assign w_bal[0] = X_balance;
  assign w_bal[1] = Y_balance;
  assign w_bal[2] = Z_balance;

  logic w_live;      // ROUND cycle in which bids are actually evaluated
  logic w_close;     // last ROUND cycle (timer expiry or start dropped)
  logic w_start;     // IDLE cycle that opens a round

  assign w_live  = (r_state == ST_ROUND) && C_start;
  assign w_close = (r_state == ST_ROUND) && (!C_start || (r_count == TIMER_W'(1)));
  assign w_start = (r_state == ST_IDLE) && C_start && r_armed;

  // ---------------------------------------------------------------------------
  // Bid evaluation and arbitration
  // ---------------------------------------------------------------------------
  logic [2:0]       w_afford;
  logic [2:0]       w_cand;
  logic             w_best_vld;
  logic [1:0]       w_best_idx;
  logic [BID_W-1:0] w_best_amt;
  logic             w_accept;
  logic             w_ldr_ret;
  logic [1:0]       w_err [3];
  logic [2:0]       w_chg;
  logic [2:0]       w_ack;
  logic [2:0]       w_leader_nxt;
  logic [BID_W-1:0] w_max_nxt;

  // Balance check is done one bit wider than the balance so that
  // bidAmt + bid_charge cannot wrap and look affordable.
  always_comb begin
    w_afford = '0;
    w_cand   = '0;
    for (int i = 0; i < 3; i++) begin
      w_afford[i] = ({1'b0, w_bal[i]} >=
                     ({1'b0, bid_charge} + {{(BAL_W+1-BID_W){1'b0}}, w_amt[i]}));
      w_cand[i]   = w_live && w_bid[i] && r_mask[i] && w_afford[i];
    end
  end

  // Strictly-greater compare in X, Y, Z order gives the X > Y > Z tie rule.
  always_comb begin
    w_best_vld = 1'b0;
    w_best_idx = 2'd0;
    w_best_amt = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_cand[i] && (!w_best_vld || (w_amt[i] > w_best_amt))) begin
        w_best_vld = 1'b1;
        w_best_idx = 2'(i);
        w_best_amt = w_amt[i];
      end
    end
  end

  assign w_accept  = w_best_vld && (w_best_amt > r_max_bid);
  // A bidder's own bid in the same cycle masks its retract.
  assign w_ldr_ret = w_live && (|(w_ret & ~w_bid & r_leader & r_mask));

  always_comb begin
    w_chg = '0;
    for (int i = 0; i < 3; i++) begin
      w_err[i] = 2'b00;
      if (w_bid[i]) begin
        if (!w_live || !r_mask[i]) begin
          w_err[i] = 2'b01;
        end else if (!w_afford[i]) begin
          w_err[i] = 2'b11;
        end else begin
          w_chg[i] = 1'b1;
          w_err[i] = (w_accept && (w_best_idx == 2'(i))) ? 2'b00 : 2'b10;
        end
      end else if (w_ret[i]) begin
        w_err[i] = (w_live && r_mask[i]) ? 2'b00 : 2'b01;
      end
    end
  end

  assign w_ack = w_bid | w_ret;

  // An accepted bid outranks a same-cycle leader retract: it was already
  // compared against the pre-retract maxBid and becomes the new leader.
  always_comb begin
    w_leader_nxt = r_leader;
    w_max_nxt    = r_max_bid;
    if (w_accept) begin
      w_leader_nxt = 3'b001 << w_best_idx;
      w_max_nxt    = w_best_amt;
    end else if (w_ldr_ret) begin
      w_leader_nxt = '0;
      w_max_nxt    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_close) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    roundOver = (r_state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Round datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload  <= DEFAULT_TIMER;
      r_count   <= '0;
      r_mask    <= '0;
      r_leader  <= '0;
      r_max_bid <= '0;
      r_win     <= '0;
      r_ready   <= 1'b0;
      r_armed   <= 1'b0;
      r_ack     <= '0;
      r_charge  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_err[i] <= 2'b00;
      end
    end else begin
      r_ack    <= w_ack;
      r_charge <= w_chg;
      r_err    <= w_err;
      case (r_state)
        ST_IDLE: begin
          if (timer_load) begin
            r_reload <= timer_value;
          end
          if (!C_start) begin
            r_armed <= 1'b1;
          end
          if (w_start) begin
            r_armed   <= 1'b0;
            r_count   <= (r_reload == '0) ? TIMER_W'(1) : r_reload;
            r_mask    <= xyz_mask;
            r_leader  <= '0;
            r_max_bid <= '0;
            r_win     <= '0;
            r_ready   <= 1'b0;
          end
        end
        ST_ROUND: begin
          r_leader  <= w_leader_nxt;
          r_max_bid <= w_max_nxt;
          if (w_close) begin
            r_win <= w_leader_nxt;
          end else begin
            r_count <= r_count - TIMER_W'(1);
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign X_ack     = r_ack[0];
  assign Y_ack     = r_ack[1];
  assign Z_ack     = r_ack[2];
  assign X_err     = r_err[0];
  assign Y_err     = r_err[1];
  assign Z_err     = r_err[2];
  assign charge_en = r_charge;
  assign X_win     = r_win[0];
  assign Y_win     = r_win[1];
  assign Z_win     = r_win[2];
  assign maxBid    = r_max_bid;
  assign ready     = r_ready;

endmodule

// File: tb/tb_bid_round_ctrl.sv
// tb/tb_bid_round_ctrl.sv - scoreboard bench for bid_round_ctrl

module tb_bid_round_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        C_start;
  logic        timer_load;
  logic [15:0] timer_value;
  logic [2:0]  xyz_mask;
  logic [31:0] bid_charge;
  logic [2:0]  bid;
  logic [2:0]  ret;
  logic [15:0] amt [3];
  logic [31:0] bal [3];

  logic        X_ack, Y_ack, Z_ack;
  logic [1:0]  X_err, Y_err, Z_err;
  logic [2:0]  charge_en;
  logic        X_win, Y_win, Z_win;
  logic [15:0] maxBid;
  logic        roundOver;
  logic        ready;

  bid_round_ctrl dut (
    .clk(clk), .reset(reset), .C_start(C_start),
    .timer_load(timer_load), .timer_value(timer_value),
    .xyz_mask(xyz_mask), .bid_charge(bid_charge),
    .X_bid(bid[0]), .Y_bid(bid[1]), .Z_bid(bid[2]),
    .X_bidAmt(amt[0]), .Y_bidAmt(amt[1]), .Z_bidAmt(amt[2]),
    .X_retract(ret[0]), .Y_retract(ret[1]), .Z_retract(ret[2]),
    .X_balance(bal[0]), .Y_balance(bal[1]), .Z_balance(bal[2]),
    .X_ack(X_ack), .Y_ack(Y_ack), .Z_ack(Z_ack),
    .X_err(X_err), .Y_err(Y_err), .Z_err(Z_err),
    .charge_en(charge_en),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .maxBid(maxBid), .roundOver(roundOver), .ready(ready)
  );

  typedef struct {
    int          stamp;
    logic [2:0]  ack;
    logic [5:0]  err;
    logic [2:0]  chg;
    logic [15:0] mx;
  } resp_t;

  typedef struct {
    int          stamp;
    logic [2:0]  win;
    logic [15:0] mx;
  } rnd_t;

  resp_t q_resp[$];
  rnd_t  q_rnd[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: round phase (0 idle, 1 bidding, 2 closing), cycles left,
  // leader index (-1 none) and current maximum bid.
  int         m_phase;
  bit         m_armed;
  int         m_left;
  int         m_reload;
  logic [2:0] m_mask;
  int         m_leader;
  int         m_max;

  task automatic model_reset();
    m_phase  = 0;
    m_armed  = 0;
    m_left   = 0;
    m_reload = 15;
    m_mask   = 3'b000;
    m_leader = -1;
    m_max    = 0;
  endtask

  task automatic model_step();
    bit    live;
    bit    cand [3];
    int    best;
    bit    acc;
    bit    ldr_ret;
    resp_t r;
    rnd_t  rr;
    live    = (m_phase == 1) && C_start;
    best    = -1;
    ldr_ret = 0;
    r.stamp = cyc + 1;
    r.ack   = bid | ret;
    r.err   = '0;
    r.chg   = '0;
    for (int i = 0; i < 3; i++) begin
      cand[i] = 0;
      if (bid[i]) begin
        if (!live || !m_mask[i]) r.err[2*i +: 2] = 2'b01;
        else if (longint'(bal[i]) < longint'(amt[i]) + longint'(bid_charge)) r.err[2*i +: 2] = 2'b11;
        else cand[i] = 1;
      end else if (ret[i]) begin
        if (live && m_mask[i]) begin
          r.err[2*i +: 2] = 2'b00;
          if (m_leader == i) ldr_ret = 1;
        end else begin
          r.err[2*i +: 2] = 2'b01;
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (cand[i] && (best < 0 || int'(amt[i]) > int'(amt[best]))) best = i;
    acc = (best >= 0) && (int'(amt[best]) > m_max);
    for (int i = 0; i < 3; i++) begin
      if (cand[i]) begin
        r.chg[i] = 1'b1;
        r.err[2*i +: 2] = (acc && i == best) ? 2'b00 : 2'b10;
      end
    end
    if (acc) begin
      m_leader = best;
      m_max    = int'(amt[best]);
    end else if (ldr_ret) begin
      m_leader = -1;
      m_max    = 0;
    end
    case (m_phase)
      0: begin
        if (!C_start) m_armed = 1;
        else if (m_armed) begin
          m_armed  = 0;
          m_phase  = 1;
          m_left   = (m_reload == 0) ? 1 : m_reload;
          m_max    = 0;
          m_leader = -1;
          m_mask   = xyz_mask;
        end
        if (timer_load) m_reload = int'(timer_value);
      end
      1: begin
        if (!C_start || m_left == 1) begin
          m_phase  = 2;
          rr.stamp = cyc + 1;
          rr.win   = (m_leader >= 0) ? (3'b001 << m_leader) : 3'b000;
          rr.mx    = 16'(m_max);
          q_rnd.push_back(rr);
        end else begin
          m_left = m_left - 1;
        end
      end
      default: m_phase = 0;
    endcase
    r.mx = 16'(m_max);
    if (r.ack != 3'b000) q_resp.push_back(r);
  endtask

  task automatic tick();
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    bid        = '0;
    ret        = '0;
    timer_load = 1'b0;
  endtask

  task automatic set_bid(input int i, input int a);
    bid[i] = 1'b1;
    amt[i] = 16'(a);
  endtask

  task automatic set_bal(input int b);
    for (int i = 0; i < 3; i++) bal[i] = 32'(b);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or result.
  bit chk_ready = 0;

  always @(posedge clk) begin
    logic [2:0] ack_now;
    logic [5:0] err_now;
    logic [5:0] emask;
    resp_t      r;
    rnd_t       rr;
    #1;
    ack_now = {Z_ack, Y_ack, X_ack};
    err_now = {Z_err, Y_err, X_err};
    emask   = {{2{ack_now[2]}}, {2{ack_now[1]}}, {2{ack_now[0]}}};
    while (q_resp.size() > 0 && q_resp[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL resp_missing: no ack at cycle %0d, required ack %b", q_resp[0].stamp, q_resp[0].ack);
      void'(q_resp.pop_front());
    end
    while (q_rnd.size() > 0 && q_rnd[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL round_missing: no roundOver at cycle %0d", q_rnd[0].stamp);
      void'(q_rnd.pop_front());
    end
    checks++;
    if ((charge_en & ~ack_now) != 3'b000) begin
      errors++;
      $display("FAIL stray_charge: charge_en=%b ack=%b", charge_en, ack_now);
    end
    if (ack_now != 3'b000) begin
      checks++;
      if (q_resp.size() == 0 || q_resp[0].stamp != cyc) begin
        errors++;
        $display("FAIL unexpected_ack: got ack=%b at cycle %0d, required none", ack_now, cyc);
      end else begin
        r = q_resp.pop_front();
        checks += 3;
        if (ack_now != r.ack) begin
          errors++;
          $display("FAIL ack: got %b required %b at cycle %0d", ack_now, r.ack, cyc);
        end
        if ((err_now & emask) != (r.err & emask)) begin
          errors++;
          $display("FAIL err: got %b required %b at cycle %0d", err_now & emask, r.err & emask, cyc);
        end
        if (charge_en != r.chg || maxBid != r.mx) begin
          errors++;
          $display("FAIL charge_maxbid: got chg=%b max=%0d required chg=%b max=%0d at cycle %0d",
                   charge_en, maxBid, r.chg, r.mx, cyc);
        end
      end
    end
    if (chk_ready && !reset) begin
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL ready: got %b required 1 at cycle %0d", ready, cyc);
      end
    end
    chk_ready = 0;
    if (roundOver) begin
      checks++;
      if (q_rnd.size() == 0 || q_rnd[0].stamp != cyc) begin
        errors++;
        $display("FAIL unexpected_roundover: got roundOver at cycle %0d, required none", cyc);
      end else begin
        rr = q_rnd.pop_front();
        checks++;
        if ({Z_win, Y_win, X_win} != rr.win || maxBid != rr.mx) begin
          errors++;
          $display("FAIL round_result: got win=%b max=%0d required win=%b max=%0d",
                   {Z_win, Y_win, X_win}, maxBid, rr.win, rr.mx);
        end
        chk_ready = 1;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    C_start     = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    xyz_mask    = 3'b111;
    bid_charge  = 32'd1;
    bid         = '0;
    ret         = '0;
    for (int i = 0; i < 3; i++) begin
      amt[i] = '0;
      bal[i] = 32'd100;
    end
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({X_ack, Y_ack, Z_ack, X_err, Y_err, Z_err, charge_en, X_win, Y_win, Z_win,
         maxBid, roundOver, ready} != '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs nonzero during reset (maxBid=%0d ready=%b)", maxBid, ready);
    end
    reset = 1'b0;

    // Default timer round, no bids; then held-high start must not reopen.
    tick();
    C_start = 1'b1;
    repeat (24) tick();

    // Timer 4: sequential X 10, Y 20, Z 20.
    C_start = 1'b0; tick();
    timer_load = 1'b1; timer_value = 16'd4; tick();
    C_start = 1'b1; tick();
    set_bid(0, 10); tick();
    set_bid(1, 20); tick();
    set_bid(2, 20); tick();
    repeat (4) tick();

    // Same-cycle arbitration with a tie.
    C_start = 1'b0; timer_load = 1'b1; timer_value = 16'd6; tick();
    C_start = 1'b1; tick();
    set_bid(0, 30); set_bid(1, 30); set_bid(2, 25); tick();
    repeat (8) tick();

    // Insufficient balance, then masked bidder.
    C_start = 1'b0; tick();
    C_start = 1'b1; tick();
    bal[0] = 32'd10; set_bid(0, 10); tick();
    bal[0] = 32'd100; repeat (7) tick();
    C_start = 1'b0; xyz_mask = 3'b110; tick();
    C_start = 1'b1; tick();
    set_bid(0, 5); ret[1] = 1'b1; tick();
    repeat (7) tick();

    // Leader retract, then a fresh low bid wins; retract racing a new bid.
    C_start = 1'b0; xyz_mask = 3'b111; timer_load = 1'b1; timer_value = 16'd0; tick();
    C_start = 1'b1; tick();
    repeat (3) tick();
    C_start = 1'b0; timer_load = 1'b1; timer_value = 16'd6; tick();
    C_start = 1'b1; tick();
    set_bid(1, 50); tick();
    ret[1] = 1'b1; tick();
    set_bid(2, 5); tick();
    ret[2] = 1'b1; set_bid(0, 7); ret[1] = 1'b1; set_bid(1, 3); tick();
    repeat (6) tick();

    // Start dropped mid-round with a bid; held high afterwards.
    C_start = 1'b0; tick();
    C_start = 1'b1; tick();
    tick();
    C_start = 1'b0; set_bid(0, 9); tick();
    C_start = 1'b1; repeat (5) tick();
    C_start = 1'b0; tick();
    C_start = 1'b1; repeat (10) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 11) == 0) C_start = ~C_start;
      xyz_mask   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      bid_charge = 32'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
        bal[i] = 32'($urandom_range(0, 80));
        amt[i] = 16'($urandom_range(0, 60));
        bid[i] = ($urandom_range(0, 2) == 0);
        ret[i] = ($urandom_range(0, 7) == 0);
      end
      if (!C_start && $urandom_range(0, 3) == 0) begin
        timer_load  = 1'b1;
        timer_value = 16'($urandom_range(0, 6));
      end
      tick();
    end

    reset   = 1'b0;
    C_start = 1'b0;
    repeat (25) tick();
    checks++;
    if (q_resp.size() != 0 || q_rnd.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses and %0d round results still pending, required 0",
               q_resp.size(), q_rnd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
